clk_divider_n: RTL and testbench
================================

# clk_divider_n

Parameterised integer clock divider that derives a slower clock, `clk_by_N`, from the core clock. The output frequency is exactly f(clk)/N. Even N always gives a 50% duty cycle. Odd N gives an exact 50% duty cycle when the half-cycle correction feature is compiled in. The block generates local slow clocks and strobes, for example peripheral clocks and blink or test clocks, inside the RV32I core support library.

## Interface
- `N`, default 3: division ratio; integer, N ≥ 2. N < 2 is an elaboration-time `$error`.
- `clk` input, 1 bit: source clock; all state updates on its rising edge, except the odd-N correction flop.
- `reset` input, 1 bit: asynchronous, active-high reset. Assertion takes effect immediately. Deassertion is synchronous to `clk`.
- `clk_by_N` output, 1 bit: divided clock, period N `clk` cycles.

## Operation
- Counter `cnt`, width max(1, $clog2(N)); counts 0..N-1 and wraps to 0 after N-1.
- Define H = ceil(N/2).
- On each rising edge: `cnt_next` = (cnt == N-1) ? 0 : cnt+1, and `pos_q` <= (`cnt_next` < H).
- Even N: `clk_by_N` = `pos_q`. High for N/2 cycles, low for N/2 cycles.
- Odd N, feature enabled:
  - `neg_q` samples `pos_q` on the falling edge of `clk`.
  - `clk_by_N` = `pos_q` & `neg_q`.
  - Result: high N/2 cycles (H − 0.5), low N/2 cycles.
- Odd N, feature disabled: `clk_by_N` = `pos_q`. High (N+1)/2 cycles, low (N−1)/2 cycles.
- Output is glitch-free: it is driven from flops directly, or from an AND of two flops that never toggle on the same edge.
- No other inputs; the divider free-runs whenever reset is low.

## Timing
- Reset values (asynchronous, immediate):
  - `cnt` = N−1
  - `pos_q` = 0
  - `neg_q` = 0
  - `clk_by_N` = 0
- Reset asserted mid-period: output drops to 0 at once, regardless of phase; no partial high pulse continues.
- Start-up, first rising `clk` edge after reset is deasserted:
  - `cnt` wraps to 0 and `pos_q` rises.
  - `clk_by_N` rises on that same edge for even N, or for odd N with the feature disabled.
  - Odd N with the feature enabled: `clk_by_N` rises on the following falling edge, half a cycle later.
- Steady state: the `clk_by_N` rising edge recurs every N `clk` cycles with fixed phase relative to the counter wrap.
- Duty-cycle edges:
  - `pos_q` falls on the rising edge where `cnt` becomes H.
  - With the feature enabled (odd N), `clk_by_N` also falls on that rising edge.
- Reset deasserted coincident with a rising edge: that edge is ignored. Counting starts at the next rising edge.

## Configuration
- Macro `CLK_DIVIDER_DUTY50_EN`.
- Defined: for odd N, the `neg_q` negative-edge flop and the AND gate are compiled in, giving an exact 50% duty cycle.
- Undefined: there is no negative-edge logic and the block is single-edge only. Odd N gives a (N+1)/2 : (N−1)/2 high/low ratio. Even N behaviour is identical either way.

## Test plan
- N=3, macro defined, 10 ns clk, reset pulsed from 5 ns to 21 ns:
  - `clk_by_N` = 0 during reset.
  - First rise half a clk after the first posedge following reset release.
  - Then 15 ns high, 15 ns low, repeating; period 30 ns.
- N=3, macro undefined, same stimulus: rises on the first posedge after release; 20 ns high, 10 ns low.
- N=4: rises on the first posedge after release; 20 ns high, 20 ns low; no negative-edge activity on the output.
- N=2: output toggles every rising edge; period 20 ns; duty 50%.
- N=5, reset reasserted while `clk_by_N` is high:
  - Output goes to 0 immediately and `cnt` reads 4.
  - After release, the first rise occurs on the next posedge (plus half a clk with the macro defined); 25 ns high, 25 ns low.
- N=7, macro defined, 100 periods: every period is exactly 70 ns, every high phase exactly 35 ns, and no glitch narrower than 5 ns appears on `clk_by_N`.

Source files
------------

// File: rtl/clk_divider_n.sv
// clk_divider_n: integer clock divider, clk_by_N = clk / N.
// Optional macro CLK_DIVIDER_DUTY50_EN: for odd N, adds a falling-edge
// flop and AND gate so the output has an exact 50% duty cycle.
`timescale 1ns/1ps
module clk_divider_n #(
  parameter int unsigned N = 3
) (
  input  logic clk,
  input  logic reset,
  output logic clk_by_N
);

  localparam int unsigned CW = (N < 3) ? 1 : $clog2(N);
  localparam int unsigned H  = (N + 1) / 2;

  // Reject ratios that cannot produce a divided clock
  if (N < 2) begin : g_bad_n
    $error("clk_divider_n: N must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pos_q, pos_d;

  // Next count wraps after N-1; pos is high for the first H counts of a period
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(N - 1)) begin
      cnt_d = '0;
    end
    pos_d = (cnt_d < CW'(H));
  end

  // Rising-edge state; reset parks the counter at N-1 so the first edge wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CW'(N - 1);
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

`ifdef CLK_DIVIDER_DUTY50_EN
  if ((N % 2) == 1) begin : g_duty50
    logic neg_q, neg_d;

    // Falling-edge copy of pos delays the rising edge by half a cycle
    always_comb begin
      neg_d = pos_q;
    end

    // Falling-edge flop; pos_q and neg_q never change on the same edge
    always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= neg_d;
      end
    end

    assign clk_by_N = pos_q & neg_q;
  end else begin : g_even
    assign clk_by_N = pos_q;
  end
`else
  assign clk_by_N = pos_q;
`endif

endmodule

// File: tb/tb_clk_divider_n.sv
// Bench for clk_divider_n: five instances (N = 2,3,4,5,7) compared every
// half clock cycle against a half-cycle phase model of the output waveform.
`timescale 1ns/1ps
module tb_clk_divider_n;

`ifdef CLK_DIVIDER_DUTY50_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif
  localparam int HIGH7 = DUTY ? 35 : 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic o2, o3, o4, o5, o7;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;   // rising edges since the last reset release

  always #5 clk = ~clk;

  clk_divider_n #(.N(2)) u2 (.clk(clk), .reset(reset), .clk_by_N(o2));
  clk_divider_n #(.N(3)) u3 (.clk(clk), .reset(reset), .clk_by_N(o3));
  clk_divider_n #(.N(4)) u4 (.clk(clk), .reset(reset), .clk_by_N(o4));
  clk_divider_n #(.N(5)) u5 (.clk(clk), .reset(reset), .clk_by_N(o5));
  clk_divider_n #(.N(7)) u7 (.clk(clk), .reset(reset), .clk_by_N(o7));

  // Expected output of a divide-by-n after kk rising edges, in half cycle hf
  function automatic bit exp_bit(int n, int kk, int hf);
    int p;
    if (kk == 0) return 1'b0;
    p = (2 * (kk - 1) + hf) % (2 * n);
    if (DUTY && (n % 2 == 1)) return (p >= 1) && (p <= n);
    return p < 2 * ((n + 1) / 2);
  endfunction

  function automatic logic [4:0] model(int kk, int hf);
    return {exp_bit(7, kk, hf), exp_bit(5, kk, hf), exp_bit(4, kk, hf),
            exp_bit(3, kk, hf), exp_bit(2, kk, hf)};
  endfunction

  // Period / high-time / glitch monitor for the N=7 output
  bit  arm7 = 1'b0;
  int  rises7 = 0, bad7 = 0;
  time t_rise7 = 0, t_edge7 = 0;
  bit  edge_seen7 = 1'b0;
  always @(o7) begin
    if (arm7) begin
      if (edge_seen7 && ($time - t_edge7) < 5) bad7++;
      edge_seen7 = 1'b1;
      t_edge7    = $time;
      if (o7 === 1'b1) begin
        if (rises7 > 0 && ($time - t_rise7) != 70) bad7++;
        rises7++;
        t_rise7 = $time;
      end else if (rises7 > 0 && ($time - t_rise7) != HIGH7) begin
        bad7++;
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({o7, o5, o4, o3, o2} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_out: got %b want 00000", {o7, o5, o4, o3, o2});
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({o7, o5, o4, o3, o2} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got %b want 00000", {o7, o5, o4, o3, o2});
      end
    end
    vectors++;
    if (u5.cnt_q !== 3'd4 || u3.cnt_q !== 2'd2) begin
      miscompares++;
      $display("FAIL reset_cnt: got n5=%0d n3=%0d want 4 2", u5.cnt_q, u3.cnt_q);
    end
  endtask

  task automatic test_steady(int cycles);
    release_reset();
    #1;
    vectors++;
    if ({o7, o5, o4, o3, o2} !== 5'b0) begin
      miscompares++;
      $display("FAIL pre_first_edge: got %b want 00000", {o7, o5, o4, o3, o2});
    end
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); k++; #1;
      vectors++;
      if ({o7, o5, o4, o3, o2} !== model(k, 0)) begin
        miscompares++;
        $display("FAIL steady k=%0d h=0: got %b want %b", k, {o7, o5, o4, o3, o2}, model(k, 0));
      end
      @(negedge clk); #1;
      vectors++;
      if ({o7, o5, o4, o3, o2} !== model(k, 1)) begin
        miscompares++;
        $display("FAIL steady k=%0d h=1: got %b want %b", k, {o7, o5, o4, o3, o2}, model(k, 1));
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    int skip = $urandom_range(0, 2);
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); k++; #1;
      if (o5 === 1'b1 && i >= skip) found = 1'b1;
      else begin
        @(negedge clk); #1;
        if (o5 === 1'b1 && i >= skip) found = 1'b1;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_reset_wait: got o5 never high want high within 40 cycles");
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({o7, o5, o4, o3, o2} !== 5'b0 || u5.cnt_q !== 3'd4) begin
      miscompares++;
      $display("FAIL mid_reset: got out=%b cnt5=%0d want 00000 4", {o7, o5, o4, o3, o2}, u5.cnt_q);
    end
    repeat (2) @(posedge clk);
    test_steady(int'($urandom_range(10, 30)));
  endtask

  task automatic test_duty7();
    @(negedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    rises7 = 0; bad7 = 0; edge_seen7 = 1'b0;
    arm7 = 1'b1;
    test_steady(700);
    arm7 = 1'b0;
    vectors++;
    if (rises7 !== 100 || bad7 !== 0) begin
      miscompares++;
      $display("FAIL duty7: got rises=%0d bad=%0d want 100 0", rises7, bad7);
    end
  endtask

  initial begin
    test_reset();
    test_steady(int'($urandom_range(20, 60)));
    repeat (3) test_mid_reset();
    test_duty7();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
